// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_REQ packet
// sources. It arbitrates round-robin, latches the winner's packet of up to
// MAX_BYTES bytes and streams it byte by byte through the txce/tx/bsy handshake.
// Optional feature macro: UART_TX_SCHED_HEADER_EN. When it is defined, every
// non-empty packet is preceded by SYNC_BYTE and then the source index byte.
module uart_tx_scheduler #(
  parameter int         NUM_REQ     = 2,
  parameter int         MAX_BYTES   = 8,
  parameter int         LEN_W       = 4,
  parameter int         GAP_CYCLES  = 16,
  parameter int         BSY_TIMEOUT = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA7
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           txce,
  output logic [7:0]                     tx,
  input  logic                           bsy,
  output logic                           busy,
  output logic                           timeout_err
);

`ifdef UART_TX_SCHED_HEADER_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W   = $clog2(MAX_BYTES + HDR_N + 1);
  localparam int CNT_MAX = (GAP_CYCLES > BSY_TIMEOUT) ? GAP_CYCLES : BSY_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] TMO_LAST = (BSY_TIMEOUT > 0) ? CNT_W'(BSY_TIMEOUT - 1) : CNT_W'(0);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [PTR_W-1:0]         rr_ptr_r, rr_ptr_nxt_s, src_r, src_nxt_s, win_s;
  logic [MAX_BYTES*8-1:0]   data_r, data_nxt_s, win_data_s;
  logic                     empty_r, empty_nxt_s, any_req_s, byte_last_s;
  logic [IDX_W-1:0]         last_r, last_nxt_s, idx_r, idx_nxt_s, pay_idx_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic [NUM_REQ-1:0]       grant_r, grant_nxt_s, done_r, done_nxt_s, win_hot_s, src_hot_s;
  logic                     txce_r, txce_nxt_s, busy_r, terr_r, terr_nxt_s;
  logic [7:0]               tx_r, tx_nxt_s, byte_sel_s;
  logic [LEN_W-1:0]         win_len_s, clamp_len_s;
  logic [2:0]               src3_s;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    j = 0;
    any_req_s = 1'b0;
    win_s = PTR_W'(0);
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_r) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end else begin
        j = j;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req_s && (i == j) && req[i]) begin
          any_req_s = 1'b1;
          win_s = PTR_W'(i);
        end else begin
          win_s = win_s;
        end
      end
    end
  end

  // Winner's length/payload mux, one-hot codes and clamped length.
  always_comb begin
    win_len_s  = LEN_W'(0);
    win_data_s = {(MAX_BYTES*8){1'b0}};
    win_hot_s  = {NUM_REQ{1'b0}};
    src_hot_s  = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      src_hot_s[i] = (src_r == PTR_W'(i));
      if (win_s == PTR_W'(i)) begin
        win_hot_s[i] = 1'b1;
        win_len_s    = req_len[i*LEN_W +: LEN_W];
        win_data_s   = req_data[i*MAX_BYTES*8 +: MAX_BYTES*8];
      end else begin
        win_hot_s[i] = 1'b0;
      end
    end
    clamp_len_s = (win_len_s > MAX_LEN) ? MAX_LEN : win_len_s;
  end

  // Byte on the wire for the current index: optional header, then payload LSB first.
  always_comb begin
    src3_s      = 3'(src_r);
    pay_idx_s   = idx_r - IDX_W'(HDR_N);
    byte_last_s = (idx_r == last_r);
    byte_sel_s  = 8'h00;
    if ((HDR_N != 0) && (idx_r == IDX_W'(0))) begin
      byte_sel_s = SYNC_BYTE;
    end else if ((HDR_N != 0) && (idx_r == IDX_W'(1))) begin
      byte_sel_s = {5'b00000, src3_s};
    end else begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (pay_idx_s == IDX_W'(k)) begin
          byte_sel_s = data_r[k*8 +: 8];
        end else begin
          byte_sel_s = byte_sel_s;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (any_req_s) state_nxt_s = LOAD; else state_nxt_s = IDLE;
      LOAD:    if (empty_r) state_nxt_s = GAP; else state_nxt_s = START;
      START:   if (!bsy) state_nxt_s = WAIT_HI; else state_nxt_s = START;
      WAIT_HI: begin
        if (bsy) begin
          state_nxt_s = WAIT_LO;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = byte_last_s ? GAP : LOAD;
        end else begin
          state_nxt_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!bsy) begin
          state_nxt_s = byte_last_s ? GAP : LOAD;
        end else begin
          state_nxt_s = WAIT_LO;
        end
      end
      GAP:     if (cnt_r == GAP_LAST) state_nxt_s = IDLE; else state_nxt_s = GAP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of outputs and packet datapath for each state.
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    src_nxt_s    = src_r;
    data_nxt_s   = data_r;
    empty_nxt_s  = empty_r;
    last_nxt_s   = last_r;
    idx_nxt_s    = idx_r;
    cnt_nxt_s    = cnt_r;
    grant_nxt_s  = {NUM_REQ{1'b0}};
    done_nxt_s   = {NUM_REQ{1'b0}};
    txce_nxt_s   = 1'b0;
    tx_nxt_s     = tx_r;
    terr_nxt_s   = terr_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_nxt_s  = win_hot_s;
          rr_ptr_nxt_s = (win_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(0) : win_s + PTR_W'(1);
          src_nxt_s    = win_s;
          data_nxt_s   = win_data_s;
          empty_nxt_s  = (clamp_len_s == LEN_W'(0));
          last_nxt_s   = IDX_W'(clamp_len_s) + IDX_W'(HDR_N) - IDX_W'(1);
          idx_nxt_s    = IDX_W'(0);
        end else begin
          grant_nxt_s  = {NUM_REQ{1'b0}};
        end
      end
      LOAD: begin
        if (empty_r) begin
          done_nxt_s = src_hot_s;
          cnt_nxt_s  = CNT_W'(0);
        end else begin
          tx_nxt_s   = byte_sel_s;
        end
      end
      START: begin
        if (!bsy) begin
          txce_nxt_s = 1'b1;
          cnt_nxt_s  = CNT_W'(0);
        end else begin
          txce_nxt_s = 1'b0;
        end
      end
      WAIT_HI, WAIT_LO: begin
        // A bsy timeout in WAIT_HI finishes the byte exactly like bsy falling.
        if ((state_r == WAIT_HI) && bsy) begin
          cnt_nxt_s = cnt_r;
        end else if ((state_r == WAIT_HI) && (cnt_r != TMO_LAST)) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if ((state_r == WAIT_LO) && bsy) begin
          cnt_nxt_s = cnt_r;
        end else begin
          if (state_r == WAIT_HI) terr_nxt_s = 1'b1; else terr_nxt_s = terr_r;
          if (byte_last_s) begin
            done_nxt_s = src_hot_s;
            cnt_nxt_s  = CNT_W'(0);
          end else begin
            idx_nxt_s  = idx_r + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) cnt_nxt_s = cnt_r; else cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Registered outputs and packet datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= PTR_W'(0);
      src_r    <= PTR_W'(0);
      data_r   <= {(MAX_BYTES*8){1'b0}};
      empty_r  <= 1'b0;
      last_r   <= IDX_W'(0);
      idx_r    <= IDX_W'(0);
      cnt_r    <= CNT_W'(0);
      grant_r  <= {NUM_REQ{1'b0}};
      done_r   <= {NUM_REQ{1'b0}};
      txce_r   <= 1'b0;
      tx_r     <= 8'h00;
      busy_r   <= 1'b0;
      terr_r   <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
      src_r    <= src_nxt_s;
      data_r   <= data_nxt_s;
      empty_r  <= empty_nxt_s;
      last_r   <= last_nxt_s;
      idx_r    <= idx_nxt_s;
      cnt_r    <= cnt_nxt_s;
      grant_r  <= grant_nxt_s;
      done_r   <= done_nxt_s;
      txce_r   <= txce_nxt_s;
      tx_r     <= tx_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      terr_r   <= terr_nxt_s;
    end
  end

  assign grant       = grant_r;
  assign done        = done_r;
  assign txce        = txce_r;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler (default parameters) with a simple
// UART model that holds bsy for `hold` clocks per byte or, when stuck, never
// raises it.
module tb_uart_tx_scheduler;
  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [7:0]   req_len;
  logic [127:0] req_data;
  logic [1:0]   grant, done;
  logic         txce;
  logic [7:0]   tx;
  logic         bsy = 1'b0;
  logic         busy, timeout_err;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         hold = 20;
  int         bsy_cnt = 0;
  int         viol = 0;
  logic       model_stuck = 1'b0;
  logic [7:0] cap_q[$];

  uart_tx_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .req_len(req_len),
    .req_data(req_data), .grant(grant), .done(done), .txce(txce),
    .tx(tx), .bsy(bsy), .busy(busy), .timeout_err(timeout_err)
  );

  // 100 MHz-style bench clock
  always #5 clock = ~clock;

  // cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // UART model: capture byte on txce, hold bsy for `hold` clocks
  always @(posedge clock) begin
    if (txce) begin
      cap_q.push_back(tx);
      if (!model_stuck) begin
        bsy     <= 1'b1;
        bsy_cnt <= hold;
      end
    end else if (bsy_cnt > 0) begin
      if (bsy_cnt == 1) bsy <= 1'b0;
      bsy_cnt <= bsy_cnt - 1;
    end
  end

  // protocol watch: txce must never coincide with bsy
  always @(negedge clock) if (txce && bsy) viol <= viol + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int s, input logic [3:0] len, input logic [63:0] bytes);
    req_len[s*4 +: 4]    = len;
    req_data[s*64 +: 64] = bytes;
  endtask

  function automatic logic [63:0] cap_bits();
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < cap_q.size() && i < 8; i++) v[i*8 +: 8] = cap_q[i];
    return v;
  endfunction

  task automatic wait_grant(input int budget, output int gc, output logic [1:0] gv);
    gc = -1; gv = 2'b00;
    for (int n = 0; n < budget && gc < 0; n++) begin
      tick();
      if (grant !== 2'b00) begin gc = cyc; gv = grant; end
    end
  endtask

  task automatic wait_done(input int budget, output int dc, output logic [1:0] dv);
    dc = -1; dv = 2'b00;
    for (int n = 0; n < budget && dc < 0; n++) begin
      tick();
      if (done !== 2'b00) begin dc = cyc; dv = done; end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy !== 1'b0; n++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00;
    tick();
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", grant); end
    tests++; if (done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b want 00", done); end
    tests++; if (txce !== 1'b0) begin fails++; $display("FAIL reset_txce: got %b want 0", txce); end
    tests++; if (tx !== 8'h00) begin fails++; $display("FAIL reset_tx: got %h want 00", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int fall_cyc, done_cyc;
    logic prev;
    logic [1:0] done_seen;
    hold = 20; cap_q.delete();
    set_src(0, 4'd3, 64'h0000_0000_0033_2211);
    req = 2'b01;
    tick();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b want 01", grant); end
    req = 2'b00;
    tick(); tick();
    tests++; if (txce !== 1'b1) begin fails++; $display("FAIL single_txce_latency: got %b want 1", txce); end
    tests++; if (tx !== 8'h11) begin fails++; $display("FAIL single_tx0: got %h want 11", tx); end
    fall_cyc = -1; done_cyc = -1; done_seen = 2'b00;
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      prev = bsy;
      tick();
      if (prev === 1'b1 && bsy === 1'b0) fall_cyc = cyc;
      if (done !== 2'b00) begin done_cyc = cyc; done_seen = done; end
    end
    tests++; if (done_seen !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", done_seen); end
    tests++; if (done_cyc != fall_cyc + 1) begin fails++; $display("FAIL single_done_timing: got cycle %0d want %0d", done_cyc, fall_cyc + 1); end
    tests++; if (cap_q.size() != 3 || cap_bits() !== 64'h332211) begin fails++; $display("FAIL single_bytes: got %0d bytes %h want 3 bytes 332211", cap_q.size(), cap_bits()); end
    for (int n = 0; n < 15; n++) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_gap: got %b want 1", busy); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_contention();
    int gcyc[4], dcyc[4];
    logic [1:0] gval[4], dval[4], exp;
    reset = 1'b1; tick(); reset = 1'b0;
    hold = 3; cap_q.delete();
    set_src(0, 4'd1, 64'hA0);
    set_src(1, 4'd1, 64'hB1);
    req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_grant(100, gcyc[p], gval[p]);
      if (p == 3) req = 2'b00;
      wait_done(100, dcyc[p], dval[p]);
    end
    for (int p = 0; p < 4; p++) begin
      exp = (p % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (gval[p] !== exp) begin fails++; $display("FAIL contention_grant%0d: got %b want %b", p, gval[p], exp); end
      tests++; if (dval[p] !== exp) begin fails++; $display("FAIL contention_done%0d: got %b want %b", p, dval[p], exp); end
      if (p > 0) begin
        tests++; if (gcyc[p] < 0 || gcyc[p] - dcyc[p-1] < 16) begin fails++; $display("FAIL contention_gap%0d: got %0d clks want >= 16", p, gcyc[p] - dcyc[p-1]); end
      end
    end
    wait_idle(100);
  endtask

  task automatic test_zero_len();
    int gc, dc;
    logic [1:0] gv, dv;
    hold = 2; cap_q.delete();
    set_src(1, 4'd0, 64'hFF);
    req = 2'b10;
    wait_grant(20, gc, gv);
    req = 2'b00;
    tests++; if (gv !== 2'b10) begin fails++; $display("FAIL zero_grant: got %b want 10", gv); end
    tick();
    tests++; if (done !== 2'b10) begin fails++; $display("FAIL zero_done_next: got %b want 10", done); end
    wait_idle(40);
    tests++; if (cap_q.size() != 0) begin fails++; $display("FAIL zero_no_txce: got %0d bytes want 0", cap_q.size()); end
    set_src(1, 4'd15, 64'h0807_0605_0403_0201);
    req = 2'b10;
    wait_grant(20, gc, gv);
    req = 2'b00;
    wait_done(400, dc, dv);
    tests++; if (dv !== 2'b10) begin fails++; $display("FAIL clamp_done: got %b want 10", dv); end
    tests++; if (cap_q.size() != 8 || cap_bits() !== 64'h0807_0605_0403_0201) begin fails++; $display("FAIL clamp_bytes: got %0d bytes %h want 8 bytes 0807060504030201", cap_q.size(), cap_bits()); end
    wait_idle(40);
  endtask

  task automatic test_timeout();
    int gc, dc, tcyc;
    logic [1:0] gv, dv;
    hold = 4; cap_q.delete(); model_stuck = 1'b1;
    set_src(0, 4'd2, 64'h4D3C);
    req = 2'b01;
    wait_grant(20, gc, gv);
    req = 2'b00;
    tcyc = -1;
    for (int n = 0; n < 20 && tcyc < 0; n++) begin
      tick();
      if (txce === 1'b1) tcyc = cyc;
    end
    tick();
    model_stuck = 1'b0;
    tests++; if (tcyc < 0 || txce !== 1'b0) begin fails++; $display("FAIL timeout_txce_pulse: got txce %b at cycle %0d want one pulse", txce, tcyc); end
    for (int n = 0; n < 6; n++) tick();
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    tick();
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
    wait_done(200, dc, dv);
    tests++; if (dv !== 2'b01) begin fails++; $display("FAIL timeout_done: got %b want 01", dv); end
    tests++; if (cap_q.size() != 2 || cap_bits() !== 64'h4D3C) begin fails++; $display("FAIL timeout_bytes: got %0d bytes %h want 2 bytes 4d3c", cap_q.size(), cap_bits()); end
    wait_idle(40);
    for (int n = 0; n < 5; n++) tick();
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_cleared: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int gc, dc, tcyc, ntx, ndone;
    logic [1:0] gv, dv;
    hold = 10; cap_q.delete();
    set_src(0, 4'd4, 64'h7473_7271);
    req = 2'b01;
    wait_grant(20, gc, gv);
    req = 2'b00;
    tcyc = -1; ntx = 0;
    for (int n = 0; n < 200 && tcyc < 0; n++) begin
      tick();
      if (txce === 1'b1) begin ntx++; if (ntx == 2) tcyc = cyc; end
    end
    tests++; if (tcyc < 0 || tx !== 8'h72) begin fails++; $display("FAIL mid_byte2: got %h want 72", tx); end
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (txce !== 1'b0) begin fails++; $display("FAIL mid_txce: got %b want 0", txce); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    tests++; if (done !== 2'b00) begin fails++; $display("FAIL mid_done: got %b want 00", done); end
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done !== 2'b00) ndone++;
    end
    tests++; if (ndone != 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses want 0", ndone); end
    cap_q.delete();
    set_src(0, 4'd2, 64'h7271);
    req = 2'b01;
    wait_grant(20, gc, gv);
    req = 2'b00;
    wait_done(200, dc, dv);
    tests++; if (dv !== 2'b01 || cap_q.size() != 2 || cap_bits() !== 64'h7271) begin fails++; $display("FAIL mid_restart: got done %b %0d bytes %h want 01 2 bytes 7271", dv, cap_q.size(), cap_bits()); end
    wait_idle(40);
  endtask

  task automatic test_header();
    int gc, dc, exp_n;
    logic [1:0] gv, dv;
    logic [63:0] exp_v;
`ifdef UART_TX_SCHED_HEADER_EN
    exp_n = 3; exp_v = 64'h5C01A7;
`else
    exp_n = 1; exp_v = 64'h5C;
`endif
    hold = 3; cap_q.delete();
    set_src(1, 4'd1, 64'h5C);
    req = 2'b10;
    wait_grant(20, gc, gv);
    req = 2'b00;
    tests++; if (gv !== 2'b10) begin fails++; $display("FAIL header_grant: got %b want 10", gv); end
    wait_done(200, dc, dv);
    tests++; if (cap_q.size() != exp_n || cap_bits() !== exp_v) begin fails++; $display("FAIL header_bytes: got %0d bytes %h want %0d bytes %h", cap_q.size(), cap_bits(), exp_n, exp_v); end
    wait_idle(40);
    tests++; if (viol != 0) begin fails++; $display("FAIL txce_while_bsy: got %0d want 0", viol); end
  endtask

  // test sequence
  initial begin
    reset = 1'b1; req = 2'b00; req_len = 8'h00; req_data = 128'h0;
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_header();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single `uart` transmitter between NUM_REQ packet sources, e.g. the nonce-found reporter and the status/heartbeat reporter.
- Arbitrates round-robin and latches the winner's packet of up to MAX_BYTES bytes.
- Streams the packet byte by byte into the UART, using the one-cycle txce pulse, the tx byte and the bsy handshake.
- Runs in the 50 MHz `clock` domain, alongside the UART core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BYTES, 8, maximum payload bytes per packet.
- LEN_W, 4, width of each length field; must hold MAX_BYTES.
- GAP_CYCLES, 16, idle clocks after each packet before the next arbitration (0 allowed).
- BSY_TIMEOUT, 8, clocks to wait for bsy to rise after txce.
- SYNC_BYTE, 8'hA7, header byte (optional feature only).

Ports:
- clock  in  1  system clock (50 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per source; level, held until grant.
- req_len  in  NUM_REQ*LEN_W  payload length per source; source i uses bits [i*LEN_W +: LEN_W].
- req_data  in  NUM_REQ*MAX_BYTES*8  payload per source; byte k of source i = [(i*MAX_BYTES+k)*8 +: 8].
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a source's packet is latched.
- done  out  NUM_REQ  one-hot, one-cycle pulse when that source's packet has finished.
- txce  out  1  to uart txce; one-cycle start pulse.
- tx  out  8  to uart tx; byte being sent.
- bsy  in  1  from uart bsy.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on a bsy timeout, cleared only by reset.

Behaviour:
- Reset (sync, highest priority, any state): next edge gives grant=0, done=0, txce=0, tx=8'h00, busy=0, timeout_err=0, rr pointer=0, state=IDLE. A packet in flight is abandoned with no done pulse.
- FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP.
- IDLE: if any req, pick the first set bit searching from rr_ptr upward (wrapping). On that cycle:
  - grant[i]=1 for that cycle only.
  - Latch req_data and len; len is clamped to MAX_BYTES.
  - Set rr_ptr=i+1 mod NUM_REQ; go to LOAD.
  - If the latched len==0: skip transmission; pulse done[i] on the next cycle; go to GAP.
- LOAD: tx <= byte[idx] (idx starts at 0, LSB byte first) -> START.
- START: wait until bsy==0, then txce=1 for exactly one cycle -> WAIT_HI. tx is stable from LOAD until the byte completes.
- WAIT_HI: wait for bsy==1 -> WAIT_LO. If BSY_TIMEOUT clocks pass without bsy rising: set timeout_err, treat the byte as sent, continue as if bsy had fallen.
- WAIT_LO: on bsy==0:
  - More bytes left: idx++ -> LOAD.
  - Last byte: done[i]=1 for one cycle -> GAP.
- GAP: count GAP_CYCLES clocks -> IDLE. GAP_CYCLES=0 means one cycle in GAP.
- Request rules:
  - Requests that arrive while not in IDLE wait; nothing is lost, since req is a level.
  - A source whose req is still high after its done is a new packet; it is re-arbitrated fairly.
  - req dropped before grant: the request is withdrawn, no grant.
- Minimum latency, one byte, bsy idle: req -> grant in 1 clk; txce 2 clks after grant.
- Only one txce per byte; txce is never asserted while bsy==1.

Optional Feature:
- Macro: UART_TX_SCHED_HEADER_EN.
- Defined: every non-empty packet is preceded by two header bytes, SYNC_BYTE then {5'b0, source index[2:0]}. Order on the wire: header, index byte, payload.
- Header bytes use the same handshake and timeout rules as payload bytes.
- len==0 still sends nothing.
- Undefined: payload bytes only; SYNC_BYTE is unused.

Test Plan:
- Single request: req[0] with len=3, data bytes 0x11,0x22,0x33; UART model holds bsy for 20 clks per byte.
  - Required: grant[0] pulse, then txce pulses with tx=0x11, 0x22, 0x33 in that order.
  - done[0] comes one clk after bsy falls on 0x33.
  - busy low after GAP_CYCLES.
- Contention: req[0] and req[1] both held high, each len=1.
  - Required: grants alternate 0,1,0,1 over 4 packets.
  - Each later grant comes no earlier than 16 clks after the previous done.
- Zero length: req[1] with len=0.
  - Required: grant[1], then done[1] next clk, no txce; with len=15, exactly 8 bytes sent (clamp).
- Bsy stuck low after txce.
  - Required: timeout_err=1 8 clks after txce, next byte proceeds; timeout_err stays 1 until reset.
- Reset mid-packet: reset for 1 clk during WAIT_LO of byte 2 of 4.
  - Required: next clk txce=0, busy=0, no done.
  - A fresh req[0] is then served from byte 0.
- With UART_TX_SCHED_HEADER_EN: req[1] len=1, data 0x5C.
  - Required: tx sequence 0xA7, 0x01, 0x5C.
